// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared defaults, control state encoding and select-width helper
package hazard_unit_pkg;

   localparam int DEF_IDX_W = 3;
   localparam int DEF_DEPTH = 2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } hz_state_e;

   // Select value 0 means register file, 1..depth name a pipeline slot.
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - decode-stage request and hazard response bundle
interface hazard_unit_if #(
   parameter int IDX_W = hazard_unit_pkg::DEF_IDX_W,
   parameter int DEPTH = hazard_unit_pkg::DEF_DEPTH,
   parameter int CNT_W = 16
);
   localparam int SEL_W = hazard_unit_pkg::sel_width(DEPTH);

   logic             id_valid;
   logic [IDX_W-1:0] id_op1;
   logic [IDX_W-1:0] id_op2;
   logic             id_use1;
   logic             id_use2;
   logic             id_wr;
   logic [IDX_W-1:0] id_rd;
   logic             id_load;
   logic             id_halt;
   logic             ex_redirect;

   logic             stall;
   logic             bubble;
   logic             flush;
   logic [SEL_W-1:0] fwd1_sel;
   logic [SEL_W-1:0] fwd2_sel;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_op1, id_op2, id_use1, id_use2, id_wr, id_rd, id_load, id_halt,
             ex_redirect,
      input  stall, bubble, flush, fwd1_sel, fwd2_sel, halted, stall_cnt
   );

   modport slave (
      input  id_valid, id_op1, id_op2, id_use1, id_use2, id_wr, id_rd, id_load, id_halt,
             ex_redirect,
      output stall, bubble, flush, fwd1_sel, fwd2_sel, halted, stall_cnt
   );

endinterface

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - in-flight destination slots with youngest-match lookup per source
module hz_scoreboard
   import hazard_unit_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SEL_W = sel_width(DEF_DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             issue,
   input  logic             in_wr,
   input  logic [IDX_W-1:0] in_rd,
   input  logic             in_load,
   input  logic [IDX_W-1:0] op1,
   input  logic             use1,
   input  logic [IDX_W-1:0] op2,
   input  logic             use2,
   output logic [SEL_W-1:0] sel1,
   output logic [SEL_W-1:0] sel2,
   output logic             wait1,
   output logic             wait2,
   output logic             busy
);

   logic [DEPTH:1]   slot_v;
   logic [DEPTH:1]   slot_ld;
   logic [IDX_W-1:0] slot_rd [1:DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_v  <= '0;
         slot_ld <= '0;
         for (int k = 1; k <= DEPTH; k++) slot_rd[k] <= '0;
      end else begin
         slot_v[1]  <= issue & in_wr;
         slot_ld[1] <= issue & in_load;
         slot_rd[1] <= in_rd;
         for (int k = 2; k <= DEPTH; k++) begin
            slot_v[k]  <= slot_v[k-1];
            slot_ld[k] <= slot_ld[k-1];
            slot_rd[k] <= slot_rd[k-1];
         end
      end
   end

   // Scan oldest to youngest so the youngest matching slot wins.
   // A load result is only usable once it reaches the last slot.
   always_comb begin
      sel1  = '0;
      sel2  = '0;
      wait1 = 1'b0;
      wait2 = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (use1 && slot_v[k] && (slot_rd[k] == op1)) begin
            sel1  = SEL_W'(k);
            wait1 = slot_ld[k] && (k < DEPTH);
         end
         if (use2 && slot_v[k] && (slot_rd[k] == op2)) begin
            sel2  = SEL_W'(k);
            wait2 = slot_ld[k] && (k < DEPTH);
         end
      end
   end

   assign busy = |slot_v;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall, bubble, flush, forwarding and halt sequencing for an in-order pipe
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rstn,
   hazard_unit_if.slave hz
);

   localparam int SEL_W = sel_width(DEPTH);

   hz_state_e        state;
   hz_state_e        state_nxt;
   logic             stall_c;
   logic             bubble_c;
   logic             flush_c;
   logic             issue;
   logic             wait1;
   logic             wait2;
   logic             busy;
   logic             load_hazard;
   logic [SEL_W-1:0] sel1;
   logic [SEL_W-1:0] sel2;
   logic [CNT_W-1:0] cnt;

   hz_scoreboard #(
      .IDX_W (IDX_W),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
   ) u_scoreboard (
      .clk     (clk),
      .rstn    (rstn),
      .issue   (issue),
      .in_wr   (hz.id_wr),
      .in_rd   (hz.id_rd),
      .in_load (hz.id_load),
      .op1     (hz.id_op1),
      .use1    (hz.id_use1),
      .op2     (hz.id_op2),
      .use2    (hz.id_use2),
      .sel1    (sel1),
      .sel2    (sel2),
      .wait1   (wait1),
      .wait2   (wait2),
      .busy    (busy)
   );

   assign load_hazard = hz.id_valid & (wait1 | wait2);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // A redirect squashes whatever sits in ID, including a pending HALT.
   always_comb begin
      stall_c   = 1'b0;
      bubble_c  = 1'b0;
      flush_c   = 1'b0;
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (hz.ex_redirect) begin
               flush_c  = 1'b1;
               bubble_c = 1'b1;
            end else if (load_hazard) begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
            if (hz.id_valid && hz.id_halt && !stall_c && !hz.ex_redirect)
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (!busy) state_nxt = ST_HALTED;
         end
         ST_HALTED: begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign issue = hz.id_valid & ~stall_c & ~hz.ex_redirect & (state == ST_RUN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (stall_c && (state != ST_HALTED) && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

   assign hz.stall     = stall_c;
   assign hz.bubble    = bubble_c;
   assign hz.flush     = flush_c;
   assign hz.fwd1_sel  = sel1;
   assign hz.fwd2_sel  = sel2;
   assign hz.halted    = (state == ST_HALTED);
   assign hz.stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vectors with queued expectations checked by a monitor
module tb_hazard_unit;

   logic clk;
   logic rstn;

   hazard_unit_if #(.IDX_W(3), .DEPTH(2), .CNT_W(4)) hz ();

   hazard_unit #(.IDX_W(3), .DEPTH(2), .CNT_W(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .hz   (hz)
   );

   typedef struct {
      string name;
      int    stall;
      int    bubble;
      int    flush;
      int    f1;
      int    f2;
      int    halted;
      int    cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input string f, input int act, input int exp);
      if (exp < 0) return;
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s.%s actual=%0d expected=%0d", n, f, act, exp);
      end
   endtask

   task automatic drive(input bit v, input bit [2:0] o1, input bit u1, input bit [2:0] o2,
                        input bit u2, input bit wr, input bit [2:0] rd, input bit ld,
                        input bit hl, input bit rx);
      hz.id_valid    = v;
      hz.id_op1      = o1;
      hz.id_use1     = u1;
      hz.id_op2      = o2;
      hz.id_use2     = u2;
      hz.id_wr       = wr;
      hz.id_rd       = rd;
      hz.id_load     = ld;
      hz.id_halt     = hl;
      hz.ex_redirect = rx;
   endtask

   task automatic step(input string n, input bit v, input bit [2:0] o1, input bit u1,
                       input bit [2:0] o2, input bit u2, input bit wr, input bit [2:0] rd,
                       input bit ld, input bit hl, input bit rx,
                       input int es, input int eb, input int ef, input int f1, input int f2,
                       input int eh, input int ec);
      exp_t e;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(v, o1, u1, o2, u2, wr, rd, ld, hl, rx);
      e = '{n, es, eb, ef, f1, f2, eh, ec};
      exp_q.push_back(e);
   endtask

   // Reset asserted mid-cycle while ID presents a reader of r1.
   task automatic rst_step(input string n);
      exp_t e;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      e = '{n, 0, 0, 0, 0, 0, 0, 0};
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "stall",     int'(hz.stall),     e.stall);
            chk(e.name, "bubble",    int'(hz.bubble),    e.bubble);
            chk(e.name, "flush",     int'(hz.flush),     e.flush);
            chk(e.name, "fwd1_sel",  int'(hz.fwd1_sel),  e.f1);
            chk(e.name, "fwd2_sel",  int'(hz.fwd2_sel),  e.f2);
            chk(e.name, "halted",    int'(hz.halted),    e.halted);
            chk(e.name, "stall_cnt", int'(hz.stall_cnt), e.cnt);
         end
      end
   end

   initial begin : stimulus
      rstn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_step("rst0");
      rst_step("rst1");
      //   name            v o1 u1 o2 u2 wr rd ld hl rx   st bu fl  f1  f2  ha cnt
      step("add_r1",        1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0);
      step("fwd_ex",        1, 1, 1, 5, 1, 1, 4, 0, 0, 0,  0, 0, 0,  1,  0, 0, 0);
      step("fwd_both",      1, 4, 1, 1, 1, 1, 4, 0, 0, 0,  0, 0, 0,  1,  2, 0, 0);
      step("youngest",      1, 4, 1, 4, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 0);
      step("ld_r0",         1, 4, 1, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0,  2,  0, 0, 0);
      step("ld_use_stall",  1, 3, 1, 0, 1, 1, 2, 0, 0, 0,  1, 1, 0,  0, -1, 0, 0);
      step("ld_use_fwd",    1, 3, 1, 0, 1, 1, 2, 0, 0, 0,  0, 0, 0,  0,  2, 0, 1);
      step("ld_r3",         1, 0, 0, 0, 0, 1, 3, 1, 0, 0,  0, 0, 0,  0,  0, 0, 1);
      step("redir_ld",      1, 3, 1, 2, 1, 1, 5, 0, 0, 1,  0, 1, 1,  1,  2, 0, 1);
      step("post_redir",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1);
      step("halt_squash",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1,  0,  0, 0, 1);
      step("add_r5",        1, 0, 0, 0, 0, 1, 5, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1);
      step("add_r6",        1, 0, 0, 0, 0, 1, 6, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1);
      step("halt",          1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0,  0, 0, 1);
      step("drain1",        1, 6, 1, 0, 0, 1, 7, 0, 0, 0,  1, 1, 0,  2,  0, 0, 1);
      step("drain2",        1, 6, 1, 0, 0, 1, 7, 0, 0, 0,  1, 1, 0,  0,  0, 0, 2);
      step("halted1",       1, 6, 1, 0, 0, 1, 7, 0, 0, 0,  1, 1, 0,  0,  0, 1, 3);
      step("halted2",       1, 6, 1, 0, 0, 1, 7, 0, 0, 0,  1, 1, 0,  0,  0, 1, 3);
      rst_step("rst_halted");
      step("add_r1b",       1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0);
      step("halt_b",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0,  0,  0, 0, 0);
      rst_step("rst_drain");
      step("after_rst",     1, 1, 1, 0, 0, 1, 3, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0);
      step("first_issue",   1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step("sat_ld",     1, 0, 0, 0, 0, 1, 2, 1, 0, 0,  0, 0, 0,  0,  0, 0, (i < 15) ? i : 15);
         step("sat_stall",  1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, -1,  0, 0, (i < 15) ? i : 15);
         step("sat_fwd",    1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  2,  0, 0, (i < 14) ? i + 1 : 15);
      end
      step("sat_final",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 15);
      rst_step("rst_final");
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_queue actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
